// File: rtl/lse_acc_seq.sv
// lse_acc_seq: sequential log-sum-exp accumulator controller.
// Streams a vector through a shared 1-cycle lse_add unit and returns the total.
//
// Ports:
//   clk, rst                   clock, async active-high reset
//   start, vec_len, mode_sel   reduction request (sampled in IDLE only)
//   in_valid/in_data/in_ready  element stream
//   pe_enable/pe_op_a/pe_op_b/pe_mode  issue port to lse_add
//   pe_result/pe_valid         result port from lse_add
//   out_valid/out_data/out_ready       result stream
//   busy                       state is not IDLE
//   err_wd                     sticky watchdog error, cleared by next start
module lse_acc_seq #(
    parameter int WIDTH     = 24,
    parameter int MAX_LEN   = 64,
    parameter int WD_CYCLES = 8,
    localparam int LEN_W    = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             start,
    input  logic [LEN_W-1:0] vec_len,
    input  logic [1:0]       mode_sel,

    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,

    output logic             pe_enable,
    output logic [WIDTH-1:0] pe_op_a,
    output logic [WIDTH-1:0] pe_op_b,
    output logic [1:0]       pe_mode,
    input  logic [WIDTH-1:0] pe_result,
    input  logic             pe_valid,

    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,

    output logic             busy,
    output logic             err_wd
);

    localparam int WD_W = $clog2(WD_CYCLES + 1);

    localparam logic [WIDTH-1:0] NEG_INF = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [WD_W-1:0]  WD_LIM  = WD_W'(WD_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] acc;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] len;
    logic [1:0]       mode;
    logic [WD_W-1:0]  wd_cnt;

    logic [LEN_W-1:0] len_sat;
    logic [LEN_W-1:0] count_inc;
    logic [WD_W-1:0]  wd_inc;

    logic start_acc;
    logic xfer;
    logic pe_take;
    logic wd_step;
    logic wd_trip;

    // Oversized requests are clamped rather than rejected.
    assign len_sat = (vec_len > LEN_MAX) ? LEN_MAX : vec_len;

    // count stays below len, so the increment cannot overflow.
    assign count_inc = count + LEN_W'(1);

    // Watchdog saturates at its limit instead of wrapping.
    assign wd_inc = (wd_cnt == WD_LIM) ? wd_cnt : wd_cnt + WD_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        pe_enable = 1'b0;
        pe_op_a   = '0;
        pe_op_b   = '0;
        pe_mode   = 2'b00;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = (state != S_IDLE);
        start_acc = 1'b0;
        xfer      = 1'b0;
        pe_take   = 1'b0;
        wd_step   = 1'b0;
        wd_trip   = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nx  = (len_sat != '0) ? S_FETCH : S_DONE;
                end
            end

            S_FETCH: begin
                in_ready  = 1'b1;
                // Issue goes out in the same cycle as the transfer.
                pe_enable = in_valid;
                pe_op_a   = acc;
                pe_op_b   = in_data;
                pe_mode   = mode;
                if (in_valid) begin
                    xfer     = 1'b1;
                    state_nx = S_WAIT;
                end
            end

            S_WAIT: begin
                if (pe_valid) begin
                    pe_take  = 1'b1;
                    state_nx = (count_inc == len) ? S_DONE : S_FETCH;
                end else begin
                    wd_step = 1'b1;
                    if (wd_inc == WD_LIM) begin
                        // Result never came back: drop the reduction.
                        wd_trip  = 1'b1;
                        state_nx = S_IDLE;
                    end
                end
            end

            S_DONE: begin
                out_valid = 1'b1;
                out_data  = acc;
                if (out_ready) begin
                    state_nx = S_IDLE;
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= NEG_INF;
            count  <= '0;
            len    <= '0;
            mode   <= 2'b00;
            wd_cnt <= '0;
            err_wd <= 1'b0;
        end else begin
            if (start_acc) begin
                acc    <= NEG_INF;
                count  <= '0;
                len    <= len_sat;
                mode   <= mode_sel;
                wd_cnt <= '0;
                err_wd <= 1'b0;
            end

            if (xfer) begin
                wd_cnt <= '0;
            end

            if (pe_take) begin
                acc   <= pe_result;
                count <= count_inc;
            end

            if (wd_step) begin
                wd_cnt <= wd_inc;
            end

            if (wd_trip) begin
                err_wd <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lse_acc_seq.sv
// tb_lse_acc_seq: self-checking bench for lse_acc_seq.
// Uses an adder stand-in for lse_add and a queue of expected results.
module tb_lse_acc_seq;

    localparam int WIDTH = 24;
    localparam int MAX_LEN = 64;
    localparam int WD = 8;
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [WIDTH-1:0] NINF = 24'h800000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] vec_len = '0;
    logic [1:0]       mode_sel = 2'b00;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             pe_enable;
    logic [WIDTH-1:0] pe_op_a;
    logic [WIDTH-1:0] pe_op_b;
    logic [1:0]       pe_mode;
    logic [WIDTH-1:0] pe_result;
    logic             pe_valid;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b1;
    logic             busy;
    logic             err_wd;

    lse_acc_seq #(
        .WIDTH(WIDTH),
        .MAX_LEN(MAX_LEN),
        .WD_CYCLES(WD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .vec_len(vec_len),
        .mode_sel(mode_sel),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .pe_enable(pe_enable),
        .pe_op_a(pe_op_a),
        .pe_op_b(pe_op_b),
        .pe_mode(pe_mode),
        .pe_result(pe_result),
        .pe_valid(pe_valid),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .busy(busy),
        .err_wd(err_wd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int c0 = 0;
    int idle_cnt = 0;
    int out_cnt = 0;
    int pe_cnt = 0;
    bit suppress = 1'b0;
    logic [1:0] cur_mode = 2'b00;

    logic [WIDTH-1:0] el [0:7];
    logic [WIDTH-1:0] sb [$];
    logic [WIDTH-1:0] pe_a_q [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] nz(input logic [WIDTH-1:0] v);
        return (v == NINF) ? '0 : v;
    endfunction

    // Stand-in for lse_add: registered a+b, NEG_INF counts as zero.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pe_valid  <= 1'b0;
            pe_result <= '0;
        end else begin
            pe_valid  <= pe_enable && !suppress;
            pe_result <= nz(pe_op_a) + nz(pe_op_b);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (!busy) idle_cnt++;
            if (out_valid) out_cnt++;
            if (pe_enable) begin
                pe_cnt++;
                pe_a_q.push_back(pe_op_a);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("sb_unexp", 32'(out_data), 32'hdead);
                else chk("out_data", 32'(out_data), 32'(sb.pop_front()));
            end
        end
    end

    task automatic do_start(input int n, input logic [1:0] m);
        start    = 1'b1;
        vec_len  = LEN_W'(n);
        mode_sel = m;
        cur_mode = m;
        c0       = cyc;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic feed(input int n, input int gap, input bit lat);
        int b;
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = el[k];
            b = 0;
            @(negedge clk);
            while (!in_ready && b < 40) begin
                @(negedge clk);
                b++;
            end
            chk("xfer_seen", 32'(in_ready), 32'd1);
            chk("pe_mode", 32'(pe_mode), 32'(cur_mode));
            if (lat) chk("xfer_cyc", 32'(cyc - c0), 32'(1 + 2 * k));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int t);
        int b;
        b = 0;
        @(negedge clk);
        while (!out_valid && b < 300) begin
            @(negedge clk);
            b++;
        end
        chk("out_seen", 32'(out_valid), 32'd1);
        t = cyc - c0;
        @(posedge clk); #1;
    endtask

    initial begin
        int t;
        int i0;
        int p0;
        int o0;

        // Reset with live-looking inputs.
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 24'h123456;
        #1 rst = 1'b1;
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_pe_en", 32'(pe_enable), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_pe_a", 32'(pe_op_a), 0);
        chk("rst_pe_b", 32'(pe_op_b), 0);
        chk("rst_err", 32'(err_wd), 0);
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk); #1;

        // Test 1: len 3, mode 01.
        el[0] = 24'h000010;
        el[1] = 24'h000020;
        el[2] = 24'h000030;
        sb.push_back(el[0] + el[1] + el[2]);
        do_start(3, 2'b01);
        i0 = idle_cnt;
        feed(3, 0, 1);
        wait_out(t);
        chk("t1_out_cyc", 32'(t), 32'd7);
        chk("t1_busy_run", 32'(idle_cnt - i0), 0);
        @(negedge clk);
        chk("t1_busy_end", 32'(busy), 0);
        @(posedge clk); #1;

        // Test 2: len 0.
        sb.push_back(NINF);
        p0 = pe_cnt;
        do_start(0, 2'b01);
        wait_out(t);
        chk("t2_out_cyc", 32'(t), 32'd1);
        chk("t2_no_pe", 32'(pe_cnt - p0), 0);

        // Test 3: len 2 with 5-cycle gaps, mode 00.
        el[0] = 24'h000005;
        el[1] = 24'h000007;
        sb.push_back(el[0] + el[1]);
        pe_a_q.delete();
        p0 = pe_cnt;
        do_start(2, 2'b00);
        feed(2, 5, 0);
        wait_out(t);
        chk("t3_pe_cnt", 32'(pe_cnt - p0), 32'd2);
        chk("t3_a0", 32'(pe_a_q[0]), 32'(NINF));
        chk("t3_a1", 32'(pe_a_q[1]), 32'(el[0]));

        // Test 4: watchdog with results suppressed.
        suppress = 1'b1;
        o0 = out_cnt;
        el[0] = 24'h000099;
        do_start(1, 2'b01);
        feed(1, 0, 1);
        repeat (WD) @(negedge clk);
        chk("t4_err_early", 32'(err_wd), 0);
        @(negedge clk);
        chk("t4_err", 32'(err_wd), 1);
        chk("t4_idle", 32'(busy), 0);
        repeat (3) @(negedge clk);
        chk("t4_no_out", 32'(out_cnt - o0), 0);
        chk("t4_err_sticky", 32'(err_wd), 1);
        @(posedge clk); #1;
        suppress = 1'b0;

        // Test 5: stalled output, ignored starts, then reset mid-WAIT.
        out_ready = 1'b0;
        el[0] = 24'h000100;
        el[1] = 24'h000200;
        sb.push_back(el[0] + el[1]);
        do_start(2, 2'b01);
        chk("t5_err_clr", 32'(err_wd), 0);
        feed(2, 0, 1);
        wait_out(t);
        chk("t5_out_cyc", 32'(t), 32'd5);
        for (int i = 0; i < 10; i++) begin
            start   = (i == 4);
            vec_len = LEN_W'(1);
            @(negedge clk);
            chk("t5_hold", 32'(out_data), 32'h000300);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("t5_start_ign", 32'(busy), 0);
        @(posedge clk); #1;

        el[0] = 24'h000011;
        o0 = out_cnt;
        do_start(2, 2'b01);
        feed(1, 0, 1);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_out", 32'(out_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("t5_rst_no_out", 32'(out_cnt - o0), 0);

        // Fresh reduction after reset, plus an oversized length clamp.
        el[0] = 24'h000042;
        sb.push_back(el[0]);
        do_start(1, 2'b00);
        feed(1, 0, 1);
        wait_out(t);
        chk("t6_out_cyc", 32'(t), 32'd3);

        for (int k = 0; k < 8; k++) el[k] = WIDTH'(k + 1);
        p0 = pe_cnt;
        do_start(100, 2'b01);
        feed(8, 0, 1);
        @(negedge clk);
        chk("t7_still_busy", 32'(busy), 1);
        chk("t7_no_out", 32'(out_valid), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t7_pe_cnt", 32'(pe_cnt - p0), 32'd8);

        @(posedge clk); #1;
        chk("sb_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got %0d exp 0", cyc);
        $fatal(1);
    end

endmodule

// File: doc/lse_acc_seq.md
LSE_ACC_SEQ -- requirements
Module: lse_acc_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, meaning operand/result width in bits.
REQ-002 The block SHALL have parameter MAX_LEN, default 64, meaning the maximum vector length; LEN_W = $clog2(MAX_LEN+1).
REQ-003 The block SHALL have parameter WD_CYCLES, default 8, meaning the watchdog limit on cycles spent waiting for a datapath result.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 start  in  1  one-cycle request to begin a reduction; sampled only in IDLE.
REQ-008 vec_len  in  LEN_W  number of elements to reduce; sampled with start.
REQ-009 mode_sel  in  2  datapath mode, sampled with start: 00 = LSE, other = linear add.
REQ-010 in_valid / in_data / in_ready  in / in / out  1 / WIDTH / 1  element stream; a transfer occurs when valid and ready are both high.
REQ-011 pe_enable / pe_op_a / pe_op_b / pe_mode  out  1 / WIDTH / WIDTH / 2  issue port to the shared lse_add unit, which has 1-cycle registered latency.
REQ-012 pe_result / pe_valid  in  WIDTH / 1  result port from lse_add.
REQ-013 out_valid / out_data / out_ready  out / out / in  1 / WIDTH / 1  result stream.
REQ-014 busy  out  1  high whenever the state is not IDLE.
REQ-015 err_wd  out  1  sticky watchdog error; cleared by the next accepted start.

Function
REQ-016 The block SHALL implement the states IDLE, FETCH, WAIT and DONE.
REQ-017 IDLE: on start, the block SHALL latch len and mode and set acc to NEG_INF (1 followed by WIDTH-1 zeros) and count to 0, then go to FETCH when len is not 0 and to DONE when len is 0.
REQ-018 A start while not in IDLE SHALL be ignored with no effect.
REQ-019 A vec_len greater than MAX_LEN SHALL be saturated to MAX_LEN.
REQ-020 FETCH: in_ready SHALL be 1.
REQ-021 FETCH: pe_enable SHALL equal in_valid combinationally, with pe_op_a = acc, pe_op_b = in_data and pe_mode = latched mode.
REQ-022 FETCH: on a transfer the block SHALL go to WAIT and clear the watchdog counter.
REQ-023 In all states other than FETCH, in_ready and pe_enable SHALL be 0.
REQ-024 WAIT: on pe_valid the block SHALL set acc to pe_result and increment count, then go to DONE if count+1 equals len and to FETCH otherwise.
REQ-025 WAIT: without pe_valid the watchdog counter SHALL increment; on reaching WD_CYCLES the block SHALL set err_wd and go to IDLE with no output.
REQ-026 A pe_valid received outside WAIT SHALL be ignored.
REQ-027 DONE: out_valid SHALL be 1 with out_data = acc held stable; on out_ready the block SHALL go to IDLE.
REQ-028 A start in the same cycle as the DONE handshake SHALL be ignored, because the state is not IDLE.
REQ-029 Throughput with in_valid held high SHALL be one element per 2 cycles.
REQ-030 Latency: with start sampled at cycle 0, element k SHALL transfer at cycle 1+2k and out_valid SHALL first assert at cycle 2N+1.
REQ-031 Latency for len = 0: out_valid SHALL assert at cycle 1 with out_data = NEG_INF.
REQ-032 The block SHALL perform no arithmetic on data; all combination is delegated to lse_add.
REQ-033 count and the watchdog counter SHALL be unsigned and SHALL never wrap; the watchdog saturates at WD_CYCLES.

Reset
REQ-034 On rst assertion, regardless of the clock, the block SHALL enter IDLE.
REQ-035 On rst assertion, acc SHALL be set to NEG_INF and count, the watchdog counter and len SHALL be set to 0.
REQ-036 On rst assertion, mode SHALL be set to 00 and err_wd SHALL be cleared.
REQ-037 During reset, in_ready, pe_enable, out_valid and busy SHALL be 0.
REQ-038 During reset, pe_op_a, pe_op_b, pe_mode and out_data SHALL be 0.
REQ-039 A reset asserted mid-reduction SHALL abandon the reduction with no output.
REQ-040 After reset is released, the first start SHALL behave as a fresh reduction.

Verification
REQ-041 Test 1: start, len=3, mode=01, elements 0x000010, 0x000020, 0x000030, lse_add model = a+b with NEG_INF treated as 0 -> out_data 0x000060 at cycle 7 and busy high during cycles 1-7.
REQ-042 Test 2: start with len=0 -> out_valid at cycle 1 with out_data 0x800000 and no pe_enable pulse.
REQ-043 Test 3: len=2 with in_valid low for 5 cycles before each element -> exactly 2 pe_enable pulses, pe_op_a of the first pulse = 0x800000, and pe_op_a of the second pulse = the first pe_result.
REQ-044 Test 4: len=1 with pe_valid suppressed -> err_wd high WD_CYCLES cycles after the issue, IDLE, no out_valid; the next start clears err_wd.
REQ-045 Test 5: out_ready held low for 10 cycles in DONE -> out_data stable and a start during those cycles ignored; rst pulsed mid-WAIT -> busy falls immediately and no out_valid follows.
